// File: rtl/alu_logical_seq.sv
// Handshaked logical/shift ALU: logical ops complete in one cycle, shifts use an
// iterative shifter moving up to SHIFT_STEP bits per cycle. One op in flight.
module alu_logical_seq #(
   parameter int WIDTH      = 32,
   parameter int SHIFT_STEP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [2:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             busy
);
   localparam int SAW = $clog2(WIDTH);
   localparam logic [SAW:0] STEP_W = (SAW+1)'(SHIFT_STEP);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [SAW-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             zero_q, zero_d;

   logic [SAW-1:0]   amt;
   logic [SAW-1:0]   rem_nxt;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] logic_res;

   function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   // Arithmetic shifts keep the MSB in place, so repeated SRA steps preserve the original sign fill.
   function automatic logic [WIDTH-1:0] shift_by(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] v,
                                                 input logic [SAW-1:0] n);
      logic [2*WIDTH-1:0] dbl;
      dbl = {v, v} << n;
      case (op)
         2'b00:   return $unsigned($signed(v) >>> n);
         2'b01:   return v >> n;
         2'b10:   return v << n;
         default: return dbl[2*WIDTH-1:WIDTH];
      endcase
   endfunction

   always_comb begin
      if ({1'b0, rem_q} < STEP_W) amt = rem_q;
      else                        amt = SAW'(SHIFT_STEP);
      rem_nxt   = rem_q - amt;
      shifted   = shift_by(op_q, work_q, amt);
      logic_res = logic_op(sel[1:0], in1, in2);
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rem_d   = rem_q;
      work_d  = work_q;
      out_d   = out_q;
      zero_d  = zero_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d  = sel[1:0];
               rem_d = in2[SAW-1:0];
               if (!sel[2]) begin
                  out_d   = logic_res;
                  zero_d  = (logic_res == '0);
                  state_d = S_DONE;
               end else if (in2[SAW-1:0] == '0) begin
                  out_d   = in1;
                  zero_d  = (in1 == '0);
                  state_d = S_DONE;
               end else begin
                  work_d  = in1;
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            work_d = shifted;
            rem_d  = rem_nxt;
            // Only the final shift result is published to out.
            if (rem_nxt == '0) begin
               out_d   = shifted;
               zero_d  = (shifted == '0);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         out_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         zero_q  <= zero_d;
      end
   end

   always_ff @(posedge clk) begin
      op_q   <= op_d;
      rem_q  <= rem_d;
      work_q <= work_d;
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
   assign out       = out_q;
   assign zero      = zero_q;
endmodule

// File: tb/tb_alu_logical_seq.sv
// Directed and swept checks of alu_logical_seq at SHIFT_STEP = 1, 4 and 32 (index 1 is STEP=4).
module tb_alu_logical_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in1, in2;
   logic [2:0]  sel;

   logic        ir [3];
   logic        ov [3];
   logic        zr [3];
   logic        bz [3];
   logic [31:0] ot [3];

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] res_a [3];
   int          lat_a [3];
   logic        zero_a [3];

   always #5 clk = ~clk;

   alu_logical_seq #(.WIDTH(32), .SHIFT_STEP(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in1(in1), .in2(in2),
      .sel(sel), .out_valid(ov[0]), .out_ready(out_ready), .out(ot[0]), .zero(zr[0]), .busy(bz[0]));
   alu_logical_seq #(.WIDTH(32), .SHIFT_STEP(4)) u_s4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in1(in1), .in2(in2),
      .sel(sel), .out_valid(ov[1]), .out_ready(out_ready), .out(ot[1]), .zero(zr[1]), .busy(bz[1]));
   alu_logical_seq #(.WIDTH(32), .SHIFT_STEP(32)) u_s32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in1(in1), .in2(in2),
      .sel(sel), .out_valid(ov[2]), .out_ready(out_ready), .out(ot[2]), .zero(zr[2]), .busy(bz[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] golden(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (s)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return ~(a | b);
         3'd4: return $unsigned($signed(a) >>> sh);
         3'd5: return a >> sh;
         3'd6: return a << sh;
         default: return (a << sh) | (a >> (32 - sh));
      endcase
   endfunction

   // Issue one op to all three DUTs with out_ready high; record result/latency per DUT.
   task automatic do_op(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
      bit seen [3];
      for (int k = 0; k < 3; k++) begin seen[k] = 0; lat_a[k] = 99; end
      out_ready = 1'b1;
      sel = s; in1 = a; in2 = b; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      in1 = 32'hDEAD_BEEF; in2 = 32'h1234_5678;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         for (int k = 0; k < 3; k++)
            if (!seen[k] && ov[k]) begin
               seen[k] = 1; lat_a[k] = cyc; res_a[k] = ot[k]; zero_a[k] = zr[k];
            end
         if (seen[0] && seen[1] && seen[2]) break;
         @(posedge clk);
         #1;
      end
      for (int k = 0; k < 3; k++)
         if (!seen[k]) chk("timeout", 32'(k), 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int step_v [3];
      logic [31:0] a, b, held;
      int exp_lat;
      step_v[0] = 1; step_v[1] = 4; step_v[2] = 32;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 3'd0; in1 = '0; in2 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(ov[1]), 32'd0);
      chk("rst_out", ot[1], 32'd0);
      chk("rst_zero", 32'(zr[1]), 32'd0);
      chk("rst_busy", 32'(bz[1]), 32'd0);
      chk("rst_in_ready", 32'(ir[1]), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_op(3'b000, 32'h1, 32'h1);
      chk("and_out", res_a[1], 32'h1);  chk("and_zero", 32'(zero_a[1]), 32'd0);
      chk("and_lat", 32'(lat_a[1]), 32'd1);
      do_op(3'b011, 32'hFFFF_FFFF, 32'h0);
      chk("nor_out", res_a[1], 32'h0);  chk("nor_zero", 32'(zero_a[1]), 32'd1);
      do_op(3'b100, 32'h8000_0010, 32'd5);
      chk("sra_out", res_a[1], 32'hFC00_0000); chk("sra_lat", 32'(lat_a[1]), 32'd3);
      do_op(3'b110, 32'h0000_0030, 32'd1);
      chk("sll_out", res_a[1], 32'h60); chk("sll_lat", 32'(lat_a[1]), 32'd2);
      do_op(3'b101, 32'hFFFF_FFFF, 32'd31);
      chk("srl31_out", res_a[1], 32'h1); chk("srl31_lat", 32'(lat_a[1]), 32'd9);
      chk("srl31_lat_s1", 32'(lat_a[0]), 32'd32); chk("srl31_lat_s32", 32'(lat_a[2]), 32'd2);
      do_op(3'b101, 32'h0000_000A, 32'd33);
      chk("srl_mask_out", res_a[1], 32'h5);
      do_op(3'b111, 32'h8000_0001, 32'd4);
      chk("rol_out", res_a[1], 32'h18);
      do_op(3'b100, 32'h1234_5678, 32'd32);
      chk("sh0_out", res_a[1], 32'h1234_5678); chk("sh0_lat", 32'(lat_a[1]), 32'd1);

      // Backpressure: result must hold while out_ready is low.
      out_ready = 1'b0;
      sel = 3'b010; in1 = 32'hF0F0_F0F0; in2 = 32'hFF00_FF00; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("bp_valid", 32'(ov[1]), 32'd1);
      held = 32'h0FF0_0FF0;
      for (int c = 0; c < 5; c++) begin
         sel = 3'b001; in1 = 32'h0000_00FF; in2 = 32'(c); in_valid = (c % 2 == 0);
         @(posedge clk);
         #1;
         chk("bp_hold_out", ot[1], held);
         chk("bp_hold_ready", {30'd0, ir[1], ov[1]}, 32'd1);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", 32'(ov[1]), 32'd0);
      chk("bp_release_ready", 32'(ir[1]), 32'd1);
      chk("bp_retain_out", ot[1], held);

      // Reset in the middle of a long shift.
      sel = 3'b101; in1 = 32'hFFFF_FFFF; in2 = 32'd31; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_busy", 32'(bz[1]), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_valid", 32'(ov[1]), 32'd0);
      chk("mid_rst_out", ot[1], 32'd0);
      chk("mid_rst_busy", 32'(bz[1]), 32'd0);
      chk("mid_rst_ready", 32'(ir[1]), 32'd1);
      rst_n = 1'b1;
      do_op(3'b000, 32'hA5A5_F00F, 32'h0FF0_FFFF);
      chk("post_rst_and", res_a[1], 32'h05A0_F00F);

      // Sweep every opcode and shift amount against the golden model.
      for (int s = 0; s < 8; s++)
         for (int sh = 0; sh < 32; sh++) begin
            a = $urandom;
            b = ($urandom & 32'hFFFF_FFE0) | 32'(sh);
            do_op(3'(s), a, b);
            for (int k = 0; k < 3; k++) begin
               exp_lat = (s < 4) ? 1 : 1 + (sh + step_v[k] - 1) / step_v[k];
               chk($sformatf("sweep_out s%0d op%0d sh%0d", step_v[k], s, sh), res_a[k], golden(3'(s), a, b));
               chk($sformatf("sweep_lat s%0d op%0d sh%0d", step_v[k], s, sh), 32'(lat_a[k]), 32'(exp_lat));
            end
         end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
